// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// = Module   : instr_fetch_pkg                                                =
// = Purpose  : Shared types and constants for the instruction fetch unit.    =
// = Contents : fetch_state_e  - fetch FSM states (LOAD, RUN, FAULT)          =
// =            INST_BYTES     - bytes per instruction word                   =
// =            NOP_INST       - NOP encoding, debug reset value of out_inst  =
// = Revision : 1.0 - initial release                                         =
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int          INST_BYTES = 4;
  localparam int          ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

endpackage : instr_fetch_pkg

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// = Module   : instr_fetch_if                                                =
// = Purpose  : Bus bundle between the fetch unit, instruction memory,        =
// =            execute (redirects) and decode (valid/ready output).          =
// = Signals  : imem_addr/imem_wr/imem_rdata   - memory read port             =
// =            redirect_valid/redirect_pc     - PC change from execute       =
// =            out_valid/out_ready/out_inst/out_pc - pair toward decode      =
// = Modports : master - the fetch unit; slave - memory/execute/decode side   =
// = Revision : 1.0 - initial release                                         =
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int WIDTH1 = 32
);

  logic [WIDTH1-1:0] imem_addr;
  logic              imem_wr;
  logic [WIDTH1-1:0] imem_rdata;
  logic              redirect_valid;
  logic [WIDTH1-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH1-1:0] out_inst;
  logic [WIDTH1-1:0] out_pc;

  modport master (
    output imem_addr, imem_wr, out_valid, out_inst, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, imem_wr, out_valid, out_inst, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface : instr_fetch_if

`default_nettype wire

// File: rtl/instr_fetch_out_reg.sv
// ============================================================================
// = Module   : fetch_out_reg                                                 =
// = Purpose  : Single valid/ready output stage holding an instruction and    =
// =            its PC. Holds its contents unless told to capture or flush.   =
// = Ports    : clk, reset_n        - clock, async active-low reset           =
// =            capture             - load inst_in/pc_in and set valid        =
// =            flush               - drop the held pair (valid <= 0)         =
// =            inst_in, pc_in      - pair to capture                         =
// =            valid, inst, pc     - registered output pair                  =
// = Revision : 1.0 - initial release                                         =
// ============================================================================
`default_nettype none

module fetch_out_reg #(
  parameter int                WIDTH1     = 32,
  parameter logic [WIDTH1-1:0] RESET_INST = '0
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              capture,
  input  wire logic              flush,
  input  wire logic [WIDTH1-1:0] inst_in,
  input  wire logic [WIDTH1-1:0] pc_in,
  output logic                   valid,
  output logic      [WIDTH1-1:0] inst,
  output logic      [WIDTH1-1:0] pc
);

  logic              valid_d, valid_q;
  logic [WIDTH1-1:0] inst_d,  inst_q;
  logic [WIDTH1-1:0] pc_d,    pc_q;

  // Flush wins over capture; a flush leaves inst/pc as they were since
  // they are meaningless while valid is low.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      inst_d  = inst_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      inst_q  <= RESET_INST;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;

endmodule : fetch_out_reg

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// = Module   : instr_fetch                                                   =
// = Purpose  : Instruction fetch unit. Owns the PC and the LOAD/RUN/FAULT    =
// =            FSM, reads the combinational instruction memory and feeds a   =
// =            single valid/ready output stage toward decode.                =
// = Ports    : clk, reset_n  - clock, async active-low reset                 =
// =            load_busy     - program load in progress, fetch holds off     =
// =            bus           - instr_fetch_if.master (memory, redirect, out) =
// =            fault         - sticky misaligned/out-of-range fetch flag     =
// =            fetch_count   - accepted handshakes, wraps                    =
// = Revision : 1.0 - initial release                                         =
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                WIDTH1          = 32,
  parameter int                MEM_SIZE        = 1024,
  parameter logic [WIDTH1-1:0] RESET_PC        = '0,
  parameter bit                DEBUG_NOP_RESET = 1'b0
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              load_busy,
  instr_fetch_if.master          bus,
  output logic                   fault,
  output logic      [WIDTH1-1:0] fetch_count
);

  localparam logic [WIDTH1-1:0] MEM_WORDS  = WIDTH1'(MEM_SIZE);
  localparam logic [WIDTH1-1:0] RESET_INST =
      DEBUG_NOP_RESET ? WIDTH1'(NOP_INST) : '0;

  fetch_state_e      state_d, state_q;
  logic [WIDTH1-1:0] pc_d,    pc_q;
  logic              fault_d, fault_q;
  logic [WIDTH1-1:0] count_d, count_q;

  logic              capture;
  logic              flush;
  logic              handshake;
  logic              pc_bad;

  // Checked against the current PC, so a bad redirect target or a wrapped
  // pc + 4 is caught on the edge after it was loaded.
  assign pc_bad    = (pc_q[ALIGN_BITS-1:0] != '0) ||
                     ((pc_q >> ALIGN_BITS) >= MEM_WORDS);
  assign handshake = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    count_d = count_q;
    capture = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      LOAD: begin
        pc_d  = RESET_PC;
        flush = 1'b1;
        if (!load_busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Decode took the pair on this edge whatever else happens to it.
        if (handshake) begin
          count_d = count_q + WIDTH1'(1);
        end
        if (pc_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
          flush   = 1'b1;
        end else if (load_busy) begin
          state_d = LOAD;
          pc_d    = RESET_PC;
          flush   = 1'b1;
        end else if (bus.redirect_valid) begin
          pc_d  = bus.redirect_pc;
          flush = 1'b1;
        end else if (!bus.out_valid || bus.out_ready) begin
          capture = 1'b1;
          pc_d    = pc_q + WIDTH1'(INST_BYTES);
        end
      end
      FAULT: begin
        // Everything frozen until reset.
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  fetch_out_reg #(
    .WIDTH1     (WIDTH1),
    .RESET_INST (RESET_INST)
  ) u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .capture (capture),
    .flush   (flush),
    .inst_in (bus.imem_rdata),
    .pc_in   (pc_q),
    .valid   (bus.out_valid),
    .inst    (bus.out_inst),
    .pc      (bus.out_pc)
  );

  assign bus.imem_addr = pc_q >> ALIGN_BITS;
  assign bus.imem_wr   = 1'b0;
  assign fault         = fault_q;
  assign fetch_count   = count_q;

endmodule : instr_fetch

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// = Module   : tb_instr_fetch                                                =
// = Purpose  : Self-checking bench for instr_fetch: directed vector table,   =
// =            async reset and small-memory range sequences, and random      =
// =            traffic checked against a behavioural model.                  =
// = Revision : 1.0 - initial release                                         =
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_busy;
  logic        load_busy8;
  logic        fault, fault8;
  logic [31:0] fetch_count, fetch_count8;

  always #5 clk = ~clk;

  instr_fetch_if #(.WIDTH1(32)) bus  ();
  instr_fetch_if #(.WIDTH1(32)) bus8 ();

  logic [31:0] imem [0:1023];

  assign bus.imem_rdata  = (bus.imem_addr  < 32'd1024) ? imem[bus.imem_addr[9:0]]  : 32'h0;
  assign bus8.imem_rdata = (bus8.imem_addr < 32'd1024) ? imem[bus8.imem_addr[9:0]] : 32'h0;

  instr_fetch #(.WIDTH1(32), .MEM_SIZE(1024), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_busy   (load_busy),
    .bus         (bus),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  instr_fetch #(.WIDTH1(32), .MEM_SIZE(8), .RESET_PC(32'h0)) dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_busy   (load_busy8),
    .bus         (bus8),
    .fault       (fault8),
    .fetch_count (fetch_count8)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        lb;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] einst;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic [31:0] ecnt;
    logic        ef;
  } vec_t;

  function automatic vec_t mk(input logic lb, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] einst,
                              input logic [31:0] epc, input logic [31:0] eaddr,
                              input logic [31:0] ecnt, input logic ef);
    vec_t v;
    v.lb = lb; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.einst = einst; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt; v.ef = ef;
    return v;
  endfunction

  vec_t vecs [15];

  // ---------------- behavioural model ----------------
  // Mode of the unit: 0 loading, 1 running, 2 faulted.
  int          m_mode;
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_opc, m_cnt;

  task automatic model_reset();
    m_mode = 0; m_valid = 1'b0; m_pc = 32'h0; m_inst = 32'h0; m_opc = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic lb, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (m_mode == 0) begin
      m_pc    = 32'h0;
      m_valid = 1'b0;
      if (!lb) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_valid && rdy) m_cnt = m_cnt + 1;
      if ((m_pc % 4) != 0 || (m_pc / 4) >= 1024) begin
        m_mode  = 2;
        m_valid = 1'b0;
      end else if (lb) begin
        m_mode  = 0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
      end else if (rv) begin
        m_pc    = rpc;
        m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        m_inst  = imem[m_pc / 4];
        m_opc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [31:0] last_pc8;

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 | i;
    imem[0] = 32'h0150_0093;
    imem[1] = 32'h0070_0113;

    load_busy           = 1'b1;
    load_busy8          = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b1;
    bus8.redirect_valid = 1'b0;
    bus8.redirect_pc    = 32'h0;
    bus8.out_ready      = 1'b1;

    // ---- reset values ----
    reset_n = 1'b0;
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_inst",  bus.out_inst,  0);
    check("rst_pc",    bus.out_pc,    0);
    check("rst_fault", fault,         0);
    check("rst_count", fetch_count,   0);
    check("rst_addr",  bus.imem_addr, 0);
    check("rst_wr",    bus.imem_wr,   0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- directed table: startup, stall, redirect during stall, bad redirect ----
    vecs[0]  = mk(1, 0, 32'h00, 1,  0, 32'h0,         32'h00, 32'h00, 0, 0);
    vecs[1]  = mk(0, 0, 32'h00, 1,  0, 32'h0,         32'h00, 32'h00, 0, 0);
    vecs[2]  = mk(0, 0, 32'h00, 1,  1, 32'h0150_0093, 32'h00, 32'h01, 0, 0);
    vecs[3]  = mk(0, 0, 32'h00, 1,  1, 32'h0070_0113, 32'h04, 32'h02, 1, 0);
    vecs[4]  = mk(0, 0, 32'h00, 1,  1, 32'h1000_0002, 32'h08, 32'h03, 2, 0);
    vecs[5]  = mk(0, 0, 32'h00, 0,  1, 32'h1000_0002, 32'h08, 32'h03, 2, 0);
    vecs[6]  = mk(0, 0, 32'h00, 0,  1, 32'h1000_0002, 32'h08, 32'h03, 2, 0);
    vecs[7]  = mk(0, 0, 32'h00, 0,  1, 32'h1000_0002, 32'h08, 32'h03, 2, 0);
    vecs[8]  = mk(0, 1, 32'h40, 0,  0, 32'h0,         32'h00, 32'h10, 2, 0);
    vecs[9]  = mk(0, 0, 32'h00, 1,  1, 32'h1000_0010, 32'h40, 32'h11, 2, 0);
    vecs[10] = mk(0, 0, 32'h00, 1,  1, 32'h1000_0011, 32'h44, 32'h12, 3, 0);
    vecs[11] = mk(0, 1, 32'h42, 1,  0, 32'h0,         32'h00, 32'h10, 4, 0);
    vecs[12] = mk(0, 0, 32'h00, 1,  0, 32'h0,         32'h00, 32'h10, 4, 1);
    vecs[13] = mk(0, 1, 32'h80, 1,  0, 32'h0,         32'h00, 32'h10, 4, 1);
    vecs[14] = mk(1, 0, 32'h00, 1,  0, 32'h0,         32'h00, 32'h10, 4, 1);

    for (int i = 0; i < 15; i++) begin
      load_busy          = vecs[i].lb;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      bus.out_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_inst", i), bus.out_inst, vecs[i].einst);
        check($sformatf("vec%0d_pc",   i), bus.out_pc,   vecs[i].epc);
      end
      check($sformatf("vec%0d_addr",  i), bus.imem_addr, vecs[i].eaddr);
      check($sformatf("vec%0d_count", i), fetch_count,   vecs[i].ecnt);
      check($sformatf("vec%0d_fault", i), fault,         vecs[i].ef);
      @(negedge clk);
    end

    // ---- asynchronous reset mid-cycle ----
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_valid", bus.out_valid, 0);
    check("areset_inst",  bus.out_inst,  0);
    check("areset_pc",    bus.out_pc,    0);
    check("areset_fault", fault,         0);
    check("areset_count", fetch_count,   0);
    check("areset_addr",  bus.imem_addr, 0);
    @(negedge clk);
    load_busy          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    reset_n            = 1'b1;
    @(posedge clk); #1;
    check("restart_e1_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("restart_e2_valid", bus.out_valid, 1);
    check("restart_e2_pc",    bus.out_pc,    32'h0);
    check("restart_e2_inst",  bus.out_inst,  32'h0150_0093);

    // ---- MEM_SIZE = 8: sequential fetch runs into the range check ----
    load_busy = 1'b1;
    pulse_reset();
    load_busy8 = 1'b0;
    last_pc8   = 32'hFFFF_FFFF;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check($sformatf("mem8_nopc20_%0d", i),
            {31'b0, bus8.out_valid && (bus8.out_pc >= 32'h20)}, 0);
      if (bus8.out_valid) last_pc8 = bus8.out_pc;
    end
    check("mem8_fault",   fault8,         1);
    check("mem8_valid",   bus8.out_valid, 0);
    check("mem8_count",   fetch_count8,   8);
    check("mem8_last_pc", last_pc8,       32'h1C);
    check("mem8_addr",    bus8.imem_addr, 32'h8);
    load_busy8 = 1'b1;

    // ---- random traffic against the model ----
    for (int seg = 0; seg < 4; seg++) begin
      load_busy          = 1'b1;
      bus.redirect_valid = 1'b0;
      pulse_reset();
      model_reset();
      for (int c = 0; c < 250; c++) begin
        load_busy          = (c < 2) || ($urandom % 40 == 0);
        bus.out_ready      = ($urandom % 4) != 0;
        bus.redirect_valid = ($urandom % 12) == 0;
        case ($urandom % 100)
          0:       bus.redirect_pc = ($urandom % 256) * 4 + 2;
          1, 2:    bus.redirect_pc = 32'hFF0;
          default: bus.redirect_pc = ($urandom % 256) * 4;
        endcase
        @(posedge clk); #1;
        model_step(load_busy, bus.redirect_valid, bus.redirect_pc, bus.out_ready);
        check("rnd_valid", bus.out_valid, m_valid);
        if (m_valid) begin
          check("rnd_inst", bus.out_inst, m_inst);
          check("rnd_pc",   bus.out_pc,   m_opc);
        end
        check("rnd_fault", fault,         (m_mode == 2) ? 32'd1 : 32'd0);
        check("rnd_count", fetch_count,   m_cnt);
        check("rnd_addr",  bus.imem_addr, m_pc >> 2);
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the read-side master of the instruction memory. It owns the program counter, drives the word address into the memory's combinational read port, and registers each instruction with its PC into a single output stage. The output stage has a valid/ready handshake toward decode. The unit accepts branch/jump redirects from execute, stays idle while the bench is loading the program, and flags misaligned or out-of-range fetches.

## Interface
- WIDTH1, 32, data/address width
- MEM_SIZE, 1024, instruction memory depth in words
- RESET_PC, 0, byte address of the first fetch
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- load_busy  in  1  program load in progress; fetch holds off
- imem_addr  out  WIDTH1  word index to memory (= pc >> 2)
- imem_wr  out  1  memory write enable; tied 0 by this block
- imem_rdata  in  WIDTH1  combinational read data for imem_addr
- redirect_valid  in  1  execute requests a PC change
- redirect_pc  in  WIDTH1  redirect target, byte address
- out_valid  out  1  instruction/PC pair available
- out_ready  in  1  decode accepts the pair this cycle
- out_inst  out  WIDTH1  fetched instruction
- out_pc  out  WIDTH1  byte PC of out_inst
- fault  out  1  sticky fetch fault
- fetch_count  out  WIDTH1  number of accepted handshakes, wraps modulo 2^WIDTH1

## Operation
- FSM states: LOAD, RUN, FAULT. Reset enters LOAD.
- LOAD:
  - pc holds RESET_PC and out_valid = 0.
  - Moves to RUN on the first edge where load_busy = 0.
  - Redirects are ignored.
- RUN, one capture per edge:
  - A capture happens when (!out_valid || out_ready). It latches out_inst <= imem_rdata, out_pc <= pc, out_valid <= 1 and pc <= pc + 4.
  - When out_valid && !out_ready, pc, out_inst, out_pc and out_valid all hold (stall).
  - An accepted handshake (out_valid && out_ready) increments fetch_count.
- Redirect (RUN only) takes priority over capture and stall at the same edge:
  - pc <= redirect_pc and out_valid <= 0, discarding the held pair.
  - fetch_count still increments if the flushed pair was handshaken in that same cycle.
- Fault detection happens in RUN before capture:
  - Conditions: pc[1:0] != 0, or (pc >> 2) >= MEM_SIZE.
  - Response: go to FAULT; no capture; out_valid <= 0; fault <= 1.
  - A redirect to a bad target is accepted; the fault is raised on the following edge.
- FAULT: pc, out_* and fetch_count are frozen and fault stays 1. Only reset exits.
- load_busy asserted in RUN returns the FSM to LOAD with pc <= RESET_PC and out_valid <= 0. This is a reload.
- pc + 4 wraps modulo 2^WIDTH1; the wrapped value is then caught by the range check.

## Timing
- Reset values: out_valid 0, out_inst 0, out_pc 0, fault 0, fetch_count 0, pc RESET_PC, imem_addr RESET_PC >> 2, imem_wr 0.
- reset_n low mid-operation clears all state immediately. It does not wait for a clock edge.
- imem_addr is combinational from the pc register. The memory read path is combinational, so a capture uses imem_rdata from the same cycle.
- Startup latency: out_valid rises 1 edge after the first edge with load_busy = 0. The first edge performs LOAD→RUN; the next edge performs the capture.
- Throughput: 1 instruction per cycle while out_ready = 1.
- Redirect at edge t: out_valid = 0 during cycle t+1; the target instruction is valid from cycle t+2.
- out_* outputs change only on clock edges (or on asynchronous reset).

## Structure
- The shared package holds:
  - state enum {LOAD, RUN, FAULT}
  - the INST_BYTES = 4 constant
  - the NOP encoding 32'h00000013, used as the reset value of out_inst only in debug builds; the default reset value stays 0
- Natural sub-module: fetch_out_reg, the valid/ready output stage holding inst/pc with flush. The PC/FSM stays in the top.

## Test plan
- Memory preloaded with imem[0] = 32'h01500093 and imem[1] = 32'h00700113; load_busy drops; out_ready = 1. Required response: out_valid rises 2 edges later with (0x01500093, pc 0), next cycle (0x00700113, pc 4), and fetch_count = 2 after the two handshakes.
- out_ready held 0 for 3 cycles while out_valid = 1 → out_inst, out_pc and pc stable; fetch_count unchanged; then a release resumes with no skipped or duplicated PC.
- Redirect to 0x40 on the same cycle as a stall → the held pair is dropped, the next valid pair is pc 0x40 with imem[16], and the bubble is exactly 1 cycle.
- Redirect to 0x42 → fault = 1 one edge later; out_valid = 0; all outputs frozen until reset_n.
- With MEM_SIZE = 8, sequential fetch reaches pc 0x20 → fault asserts and no pair with pc 0x20 is ever valid.
- reset_n pulsed low mid-stream, asynchronous to clk → outputs go to their reset values immediately; after release with load_busy = 0, fetch restarts at RESET_PC.
